// File: rtl/systolic_ctrl_pkg.sv
// Shared state encoding and sizing helpers for the systolic MAC job sequencer.
package systolic_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        LOAD  = 3'd2,
        FLUSH = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } ctrl_state_e;

    // Cycles needed to push the last operand through a skewed ROWSxCOLS array.
    function automatic int flush_cycles(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

endpackage

// File: rtl/tc_counter.sv
// Up-counter with terminal-count compare; saturates at tc_val until cleared.
module tc_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] tc_val,
    output logic [W-1:0] cnt,
    output logic         tc
);

    assign tc = (cnt == tc_val);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/systolic_mac_ctrl.sv
// Job sequencer for the systolic MAC array: clear, load k beats, flush, drain ROWS rows.
//
// state | meaning
// IDLE  | waiting for a legal start; k_len latched on accept
// CLR   | one-cycle accumulator clear
// LOAD  | accepting operand beats until k have been taken
// FLUSH | shifting zeros through the skewed pipeline
// DRAIN | presenting result rows 0..ROWS-1 to the writer
// DONE  | one-cycle completion pulse
module systolic_mac_ctrl
    import systolic_ctrl_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int K_MAX = 16,
    parameter int KW    = $clog2(K_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [KW-1:0]           k_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    feed_en,
    output logic                    acc_clr,
    output logic                    flush_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(ROWS)-1:0] out_row,
    output logic [KW-1:0]           beat_cnt,
    output logic                    busy,
    output logic                    done
);

    localparam int RW           = $clog2(ROWS);
    localparam int FLUSH_CYCLES = flush_cycles(ROWS, COLS);
    localparam int FW           = $clog2(FLUSH_CYCLES);

    ctrl_state_e   state_q;
    ctrl_state_e   state_nxt;
    logic [KW-1:0] k_q;
    logic          start_ok;
    logic          out_hs;
    logic          beat_tc;
    logic          flush_tc;
    logic          row_tc;
    logic [FW-1:0] unused_flush_cnt;

    logic in_ready_nxt;
    logic acc_clr_nxt;
    logic flush_en_nxt;
    logic out_valid_nxt;
    logic busy_nxt;
    logic done_nxt;

    assign start_ok = start && (k_len != '0) && (k_len <= KW'(K_MAX));
    assign feed_en  = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    // Outputs are registered from the next-state decode so they line up with state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            k_q       <= '0;
            in_ready  <= 1'b0;
            acc_clr   <= 1'b0;
            flush_en  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            if (state_q == IDLE && start_ok) begin
                k_q <= k_len;
            end
            in_ready  <= in_ready_nxt;
            acc_clr   <= acc_clr_nxt;
            flush_en  <= flush_en_nxt;
            out_valid <= out_valid_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            IDLE:    if (start_ok) state_nxt = CLR;
            CLR:     state_nxt = LOAD;
            LOAD:    if (feed_en && beat_tc) state_nxt = FLUSH;
            FLUSH:   if (flush_tc) state_nxt = DRAIN;
            DRAIN:   if (out_hs && row_tc) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready_nxt  = (state_nxt == LOAD);
        acc_clr_nxt   = (state_nxt == CLR);
        flush_en_nxt  = (state_nxt == FLUSH);
        out_valid_nxt = (state_nxt == DRAIN);
        busy_nxt      = (state_nxt != IDLE);
        done_nxt      = (state_nxt == DONE);
    end

    tc_counter #(.W(KW)) u_beat_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (feed_en),
        .clr    (feed_en && beat_tc),
        .tc_val (k_q - 1'b1),
        .cnt    (beat_cnt),
        .tc     (beat_tc)
    );

    tc_counter #(.W(FW)) u_flush_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (state_q == FLUSH),
        .clr    ((state_q == FLUSH) && flush_tc),
        .tc_val (FW'(FLUSH_CYCLES - 1)),
        .cnt    (unused_flush_cnt),
        .tc     (flush_tc)
    );

    tc_counter #(.W(RW)) u_row_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (out_hs),
        .clr    (out_hs && row_tc),
        .tc_val (RW'(ROWS - 1)),
        .cnt    (out_row),
        .tc     (row_tc)
    );

endmodule

// File: tb/tb_systolic_mac_ctrl.sv
// Scoreboard bench for systolic_mac_ctrl: expected rows and done timing queued at start.
module tb_systolic_mac_ctrl;

    localparam int ROWS    = 4;
    localparam int COLS    = 4;
    localparam int K_MAX   = 16;
    localparam int KW      = $clog2(K_MAX + 1);
    localparam int RW      = $clog2(ROWS);
    localparam int FLUSH_N = ROWS + COLS - 1;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          start     = 1'b0;
    logic [KW-1:0] k_len     = '0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic          in_ready, feed_en, acc_clr, flush_en, out_valid, busy, done;
    logic [RW-1:0] out_row;
    logic [KW-1:0] beat_cnt;

    typedef struct {
        int k;
        int done_cyc;
    } job_t;

    job_t job_q[$];
    int   row_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   iv_mode = 1;
    int   stall_req = 0;
    int   stall_used = 0;
    logic fe_last = 1'b0;
    int   fe_cnt = 0;
    int   clr_cnt = 0;
    int   fl_cnt = 0;

    systolic_mac_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX), .KW(KW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .k_len     (k_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .feed_en   (feed_en),
        .acc_clr   (acc_clr),
        .flush_en  (flush_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .beat_cnt  (beat_cnt),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Start-sample cycle to done cycle with no stalls.
    function automatic int job_lat(input int k);
        return 2 + k + FLUSH_N + ROWS;
    endfunction

    // Upstream/downstream drivers: in_valid pattern and a one-off out_ready stall at row 1.
    always @(posedge clk) begin
        #1;
        case (iv_mode)
            0:       in_valid = 1'b0;
            1:       in_valid = 1'b1;
            default: in_valid = !fe_last;
        endcase
        if (stall_req == 0) stall_used = 0;
        if (out_valid && out_row == RW'(1) && stall_used < stall_req) begin
            out_ready = 1'b0;
            stall_used++;
        end else begin
            out_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            fe_cnt  = 0;
            clr_cnt = 0;
            fl_cnt  = 0;
            fe_last = 1'b0;
        end else begin
            if (acc_clr) clr_cnt++;
            if (flush_en) fl_cnt++;
            if (feed_en) begin
                chk("beat_cnt", int'(beat_cnt), fe_cnt);
                fe_cnt++;
            end
            fe_last = feed_en;
            if (out_valid) begin
                if (row_q.size() == 0) chk("row_unexpected", int'(out_valid), 0);
                else if (out_ready) chk("row", int'(out_row), row_q.pop_front());
                else chk("row_hold", int'(out_row), row_q[0]);
            end
            if (done) begin
                if (job_q.size() == 0) begin
                    chk("done_unexpected", int'(done), 0);
                end else begin
                    job_t j;
                    j = job_q.pop_front();
                    chk("done_cycle", cyc, j.done_cyc);
                    chk("feed_beats", fe_cnt, j.k);
                    chk("acc_clr_cycles", clr_cnt, 1);
                    chk("flush_cycles", fl_cnt, FLUSH_N);
                    chk("busy_in_done", int'(busy), 1);
                end
                fe_cnt  = 0;
                clr_cnt = 0;
                fl_cnt  = 0;
            end
        end
    end

    task automatic push_job(input int k, input int done_cyc);
        job_q.push_back('{k: k, done_cyc: done_cyc});
        for (int r = 0; r < ROWS; r++) row_q.push_back(r);
    endtask

    task automatic start_job(input int k, input int extra);
        @(posedge clk); #1;
        start = 1'b1;
        k_len = KW'(k);
        push_job(k, cyc + job_lat(k) + extra);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic bad_start(input int k);
        @(posedge clk); #1;
        start = 1'b1;
        k_len = KW'(k);
        @(posedge clk); #1;
        start = 1'b0;
        chk("bad_k_busy", int'(busy), 0);
        @(negedge clk);
        chk("bad_k_clr", int'(acc_clr), 0);
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!busy && job_q.size() == 0) break;
        end
        chk("idle_timeout", job_q.size(), 0);
    endtask

    task automatic wait_beat(input int b, input int bound);
        int seen;
        seen = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (in_ready && int'(beat_cnt) == b) begin
                seen = 1;
                break;
            end
        end
        chk("beat_wait", seen, 1);
    endtask

    initial begin
        int c;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", int'({in_ready, feed_en, acc_clr, flush_en, out_valid,
                                out_row, beat_cnt, busy, done}), 0);
        reset = 1'b0;

        // streaming job
        start_job(7, 0);
        wait_idle(100);

        // in_valid gaps after every beat: six extra LOAD cycles
        iv_mode = 2;
        start_job(7, 6);
        wait_idle(100);
        iv_mode = 1;

        // writer stalls three cycles on row 1
        stall_req = 3;
        start_job(7, 3);
        wait_idle(100);
        stall_req = 0;

        // illegal k_len values, then a start pulse during LOAD
        bad_start(0);
        bad_start(K_MAX + 1);
        start_job(7, 0);
        wait_beat(2, 50);
        @(posedge clk); #1;
        start = 1'b1;
        k_len = KW'(3);
        repeat (3) begin
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_idle(100);

        // async reset in the middle of LOAD aborts with no done pulse
        @(posedge clk); #1;
        start = 1'b1;
        k_len = KW'(7);
        @(posedge clk); #1;
        start = 1'b0;
        wait_beat(4, 50);
        reset = 1'b1;
        #1;
        chk("mid_reset_outs", int'({in_ready, feed_en, acc_clr, flush_en, out_valid,
                                    out_row, beat_cnt, busy, done}), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        start_job(3, 0);
        wait_idle(100);

        // start held high: DONE-cycle start ignored, next job sampled in IDLE
        @(posedge clk); #1;
        c = cyc;
        start = 1'b1;
        k_len = KW'(2);
        push_job(2, c + job_lat(2));
        push_job(2, c + job_lat(2) + 1 + job_lat(2));
        repeat (job_lat(2) + 1) @(posedge clk);
        #1;
        chk("b2b_idle_gap", int'(busy), 0);
        @(posedge clk); #1;
        chk("b2b_second_clr", int'(acc_clr), 1);
        start = 1'b0;
        wait_idle(100);

        chk("rows_left", row_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: cycle %0d expected completion", cyc);
        $fatal(1, "bench time limit reached");
    end

endmodule
